frame_buffer_reader: RTL and testbench
======================================

# frame_buffer_reader

- Read-side responder for the stereo camera frame FIFOs.
- Serves pixels to the disparity engine: on a `new_image` request it resets the read pointer of the FIFO chosen by `image_sel`, then waits for that FIFO to hold a complete frame.
- It then streams WIDTH×HEIGHT bytes, one per accepted `buffer_href` strobe inside a `buffer_vref` window, each marked by `buffer_ready`.
- Sits between the left/right capture FIFOs and the disparity engine.

## Interface

- Reset: one clock; reset is synchronous and active-low.
- Parameters:
  - WIDTH, 47, pixels per row.
  - HEIGHT, 30, rows per frame.
  - RD_LATENCY, 1, FIFO clocks from `fifo_re` sampled to data valid (1..3).
  - RRST_CYCLES, 2, cycles `fifo_rrst` is held.
- Ports:
  - clk  in  1  read clock.
  - reset_n  in  1  synchronous active-low reset.
  - new_image  in  1  one-cycle request to start a frame readout.
  - image_sel  in  1  0 = left, 1 = right; sampled only when `new_image` is high.
  - buffer_vref  in  1  consumer frame window; requests are ignored while low.
  - buffer_href  in  1  per-pixel read request strobe.
  - image_data  out  8  pixel byte.
  - buffer_ready  out  1  `image_data` valid, one cycle per pixel.
  - frame_done  out  1  one-cycle pulse after the last pixel is delivered.
  - fifo_rrst  out  2  read-pointer reset, active-high; bit0 = left, bit1 = right.
  - fifo_re  out  2  FIFO read enable; bit0 = left, bit1 = right.
  - fifo_dl  in  8  left FIFO data.
  - fifo_dr  in  8  right FIFO data.
  - frame_stored  in  2  the write side holds a complete frame; bit0 = left, bit1 = right.

## Operation

- States: IDLE, RRST, WAIT, STREAM, DRAIN, DONE.
- IDLE:
  - `new_image` → RRST.
  - `sel` latched from `image_sel`.
  - Pixel counters `col` and `row` cleared.
- RRST:
  - `fifo_rrst[sel]` high for exactly RRST_CYCLES cycles, then → WAIT.
- WAIT:
  - Hold until `frame_stored[sel]` is high, then → STREAM.
- STREAM:
  - A request is accepted on a rising edge where `buffer_vref` and `buffer_href` are both high and fewer than WIDTH×HEIGHT requests have been accepted.
  - At most one request is accepted per cycle.
  - `col` wraps at WIDTH-1; on wrap `row` increments.
  - When the request for `row` = HEIGHT-1 and `col` = WIDTH-1 is accepted → DRAIN.
  - Requests with `buffer_vref` low are dropped and the counters hold. Dropping `buffer_vref` mid-frame pauses the readout; it does not abort it.
- DRAIN:
  - Wait until the valid pipeline is empty, then → DONE.
- DONE:
  - `frame_done` high for one cycle, then → IDLE.
- Restart:
  - `new_image` in any state other than IDLE latches a new `sel`, clears the counters, flushes the in-flight pipeline, and → RRST.
  - Flushed reads never raise `buffer_ready`.
  - `new_image` takes precedence over every other transition in the same cycle.
- Data path:
  - `image_data` is taken from `fifo_dl` or `fifo_dr` according to `sel`.
  - The valid shift register is RD_LATENCY+1 deep.
  - Only `fifo_re[sel]` ever asserts; the other bit stays 0.
  - `fifo_rrst` and `fifo_re` never assert together.

## Timing

- Reset values: `image_data` = 0, `buffer_ready` = 0, `frame_done` = 0, `fifo_rrst` = 0, `fifo_re` = 0.
- Reset state: IDLE with `sel` = 0 and counters = 0.
- Reset mid-frame returns to IDLE on the next edge, with no further `buffer_ready` pulses.
- Request accepted at edge N:
  - `fifo_re[sel]` is high in the cycle N..N+1 (registered).
  - FIFO data is sampled at edge N+RD_LATENCY+1.
  - `buffer_ready` and `image_data` are valid in the cycle starting at that edge.
- Back-to-back requests sustain one pixel per cycle.
- `new_image` at edge N → `fifo_rrst[sel]` high for the cycles starting at edges N+1 .. N+RRST_CYCLES.
- `frame_done` is asserted the cycle after the final `buffer_ready`.

## Configuration

- Macro: `FRAME_READER_TESTPAT_EN`.
- Defined:
  - FIFO data is ignored.
  - `image_data` = (row×WIDTH + col) mod 256 of the delivered pixel.
  - `frame_stored` is treated as always high, so WAIT lasts one cycle.
  - `fifo_re` stays 0 while the handshake, `fifo_rrst` and latency are unchanged.
- Undefined: normal FIFO readout as described above.

## Test plan

- WIDTH=4, HEIGHT=2, RD_LATENCY=1; `new_image` with `image_sel`=1; `frame_stored`=2'b10; `buffer_vref`=1; `buffer_href` held high → `fifo_rrst`=2'b10 for 2 cycles, then 8 consecutive `fifo_re`=2'b10 cycles. Eight `buffer_ready` pulses carry `fifo_dr` values 0x10..0x17, with the first 2 cycles after the first `fifo_re`. Then one `frame_done` pulse, and `fifo_re[0]` is never set.
- Same setup, but `frame_stored`=0 for 20 cycles after RRST → no `fifo_re` and no `buffer_ready` until `frame_stored[1]` rises; streaming then starts on the next accepted request.
- `buffer_vref` drops after pixel 3 for 5 cycles while `buffer_href` stays high → `fifo_re` pauses and the counters hold; pixels 4..7 resume, and exactly 8 pixels are delivered in total.
- `new_image` with `image_sel`=0 reasserted while pixel 5 is in flight → no `buffer_ready` for the flushed read; `fifo_rrst`=2'b01; a full 8-pixel left frame follows.
- `reset_n` low for 1 cycle mid-STREAM → all outputs are 0 the next cycle and no `frame_done`; a subsequent `new_image` runs a clean frame.
- With `FRAME_READER_TESTPAT_EN` defined, WIDTH=4, HEIGHT=2 → `image_data` sequence 0..7, `fifo_re` always 0.

Source files
------------

// File: rtl/frame_buffer_reader.sv
// Read-side responder: resets the selected capture FIFO, waits for a full frame, then streams
// WIDTH*HEIGHT bytes to the disparity engine. Define FRAME_READER_TESTPAT_EN for a counting pattern.
module frame_buffer_reader #(
    parameter int unsigned WIDTH       = 47,
    parameter int unsigned HEIGHT      = 30,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned RRST_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_image,
    input  logic       image_sel,
    input  logic       buffer_vref,
    input  logic       buffer_href,
    output logic [7:0] image_data,
    output logic       buffer_ready,
    output logic       frame_done,
    output logic [1:0] fifo_rrst,
    output logic [1:0] fifo_re,
    input  logic [7:0] fifo_dl,
    input  logic [7:0] fifo_dr,
    input  logic [1:0] frame_stored
);

    localparam int unsigned COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned RCNT_W = $clog2(RRST_CYCLES + 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RRST_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StRrst, StWait, StStream, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [RD_LATENCY:0] vld_q, vld_d;
    logic [1:0]        fifo_re_q, fifo_re_d;
    logic [1:0]        fifo_rrst_q, fifo_rrst_d;
    logic [7:0]        data_q, data_d;
    logic              ready_q, ready_d;
    logic              accept, flush, frame_avail;
    logic [1:0]        sel_onehot;

`ifdef FRAME_READER_TESTPAT_EN
    logic [7:0] pix_cnt_q, pix_cnt_d;
    logic       unused_inputs;
    assign unused_inputs = ^{fifo_dl, fifo_dr, frame_stored};
    assign frame_avail   = 1'b1;
`else
    assign frame_avail = frame_stored[sel_q];
`endif

    assign sel_onehot = sel_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        col_d   = col_q;
        row_d   = row_q;
        rcnt_d  = rcnt_q;
        accept  = 1'b0;
        flush   = 1'b0;
        if (new_image) begin
            // Restart wins over every other transition and discards reads in flight.
            state_d = StRrst;
            sel_d   = image_sel;
            col_d   = '0;
            row_d   = '0;
            rcnt_d  = '0;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    col_d = '0;
                    row_d = '0;
                end
                StRrst: begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == RCNT_LAST) begin
                        rcnt_d  = '0;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (frame_avail) state_d = StStream;
                end
                StStream: begin
                    if (buffer_vref && buffer_href) begin
                        accept = 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) state_d = StDrain;
                            else                   row_d   = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (vld_q == '0) state_d = StDone;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        fifo_rrst_d = (!new_image && state_q == StRrst) ? sel_onehot : 2'b00;
`ifdef FRAME_READER_TESTPAT_EN
        fifo_re_d   = 2'b00;
`else
        fifo_re_d   = accept ? sel_onehot : 2'b00;
`endif
        vld_d   = flush ? '0 : {vld_q[RD_LATENCY-1:0], accept};
        ready_d = !flush && vld_q[RD_LATENCY];
        data_d  = data_q;
`ifdef FRAME_READER_TESTPAT_EN
        pix_cnt_d = flush ? 8'd0 : pix_cnt_q;
        if (ready_d) begin
            data_d    = pix_cnt_q;
            pix_cnt_d = pix_cnt_q + 8'd1;
        end
`else
        if (ready_d) data_d = sel_q ? fifo_dr : fifo_dl;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            rcnt_q      <= '0;
            vld_q       <= '0;
            fifo_re_q   <= 2'b00;
            fifo_rrst_q <= 2'b00;
            data_q      <= 8'd0;
            ready_q     <= 1'b0;
`ifdef FRAME_READER_TESTPAT_EN
            pix_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rcnt_q      <= rcnt_d;
            vld_q       <= vld_d;
            fifo_re_q   <= fifo_re_d;
            fifo_rrst_q <= fifo_rrst_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
`ifdef FRAME_READER_TESTPAT_EN
            pix_cnt_q   <= pix_cnt_d;
`endif
        end
    end

    assign image_data   = data_q;
    assign buffer_ready = ready_q;
    assign frame_done   = (state_q == StDone);
    assign fifo_rrst    = fifo_rrst_q;
    assign fifo_re      = fifo_re_q;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader with a 4x2 frame and a one-cycle-latency FIFO model.
module tb_frame_buffer_reader;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned NPIX = W * H;

    logic       clk = 1'b0;
    logic       reset_n, new_image, image_sel, buffer_vref, buffer_href;
    logic [7:0] image_data, fifo_dl, fifo_dr;
    logic       buffer_ready, frame_done;
    logic [1:0] fifo_rrst, fifo_re, frame_stored;

    int errors = 0;
    int checks = 0;

    frame_buffer_reader #(
        .WIDTH(W), .HEIGHT(H), .RD_LATENCY(1), .RRST_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .new_image(new_image), .image_sel(image_sel),
        .buffer_vref(buffer_vref), .buffer_href(buffer_href), .image_data(image_data),
        .buffer_ready(buffer_ready), .frame_done(frame_done), .fifo_rrst(fifo_rrst),
        .fifo_re(fifo_re), .fifo_dl(fifo_dl), .fifo_dr(fifo_dr), .frame_stored(frame_stored)
    );

    always #5 clk = ~clk;

    // FIFO model: left holds 0x20+n, right 0x10+n; registered read, one clock latency.
    logic [7:0] lptr = 8'd0, rptr = 8'd0;
    initial begin
        fifo_dl = 8'd0;
        fifo_dr = 8'd0;
    end
    always @(posedge clk) begin
        if (fifo_rrst[0]) lptr <= 8'd0;
        else if (fifo_re[0]) begin
            fifo_dl <= 8'h20 + lptr;
            lptr    <= lptr + 8'd1;
        end
        if (fifo_rrst[1]) rptr <= 8'd0;
        else if (fifo_re[1]) begin
            fifo_dr <= 8'h10 + rptr;
            rptr    <= rptr + 8'd1;
        end
    end

    // Observation monitor, sampled on the falling edge.
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int cyc = 0;
    int done_cnt, re0_cnt, re1_cnt, rrst0_cnt, rrst1_cnt, overlap_cnt;
    int first_re, first_rdy, last_rdy, done_cyc;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (buffer_ready) begin
            obs_q.push_back(image_data);
            last_rdy = cyc;
            if (first_rdy < 0) first_rdy = cyc;
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (fifo_re[0]) re0_cnt = re0_cnt + 1;
        if (fifo_re[1]) begin
            re1_cnt = re1_cnt + 1;
            if (first_re < 0) first_re = cyc;
        end
        if (fifo_rrst[0]) rrst0_cnt = rrst0_cnt + 1;
        if (fifo_rrst[1]) rrst1_cnt = rrst1_cnt + 1;
        if (|fifo_rrst && |fifo_re) overlap_cnt = overlap_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0; re0_cnt = 0; re1_cnt = 0; rrst0_cnt = 0; rrst1_cnt = 0;
        overlap_cnt = 0; first_re = -1; first_rdy = -1; last_rdy = -1; done_cyc = -1;
    endtask

    task automatic start_frame(input logic sel);
        new_image = 1'b1;
        image_sel = sel;
        tick();
        new_image = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (image_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %h want 00", image_data); end
        checks++; if (buffer_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", buffer_ready); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (fifo_rrst !== 2'b00) begin errors++; $display("FAIL reset_rrst: got %b want 00", fifo_rrst); end
        checks++; if (fifo_re !== 2'b00) begin errors++; $display("FAIL reset_re: got %b want 00", fifo_re); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] e, o;
        clear_obs();
        frame_stored = 2'b10;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'h10 + 8'(i));
        start_frame(1'b1);
        checks++; if (fifo_rrst !== 2'b00) begin errors++; $display("FAIL basic_rrst0: got %b want 00", fifo_rrst); end
        tick();
        checks++; if (fifo_rrst !== 2'b10) begin errors++; $display("FAIL basic_rrst1: got %b want 10", fifo_rrst); end
        tick();
        checks++; if (fifo_rrst !== 2'b10) begin errors++; $display("FAIL basic_rrst2: got %b want 10", fifo_rrst); end
        tick();
        checks++; if (fifo_rrst !== 2'b00) begin errors++; $display("FAIL basic_rrst3: got %b want 00", fifo_rrst); end
        wait_done(40);
        checks++; if (obs_q.size() != NPIX) begin errors++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), NPIX); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL basic_data: got %h want %h", o, e); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
        checks++; if (done_cyc != last_rdy + 1) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, last_rdy + 1); end
        checks++; if (first_rdy - first_re != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", first_rdy - first_re); end
        checks++; if (re1_cnt != NPIX) begin errors++; $display("FAIL basic_re1: got %0d want %0d", re1_cnt, NPIX); end
        checks++; if (last_rdy - first_rdy != NPIX - 1) begin errors++; $display("FAIL basic_b2b: got %0d want %0d", last_rdy - first_rdy, NPIX - 1); end
        checks++; if (re0_cnt != 0) begin errors++; $display("FAIL basic_re0: got %0d want 0", re0_cnt); end
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL basic_overlap: got %0d want 0", overlap_cnt); end
    endtask

    task automatic test_wait_frame();
        logic [7:0] e, o;
        clear_obs();
        frame_stored = 2'b00;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'h10 + 8'(i));
        start_frame(1'b1);
        repeat (22) tick();
        checks++; if (re1_cnt != 0) begin errors++; $display("FAIL wait_re: got %0d want 0", re1_cnt); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wait_ready: got %0d want 0", obs_q.size()); end
        frame_stored = 2'b10;
        wait_done(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL wait_data: got %h want %h", o, e); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wait_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_pause();
        logic [7:0] e, o;
        clear_obs();
        frame_stored = 2'b10;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'h10 + 8'(i));
        start_frame(1'b1);
        for (int i = 0; i < 30 && re1_cnt < 4; i++) tick();
        buffer_vref = 1'b0;
        repeat (5) tick();
        checks++; if (re1_cnt != 4) begin errors++; $display("FAIL pause_re: got %0d want 4", re1_cnt); end
        buffer_vref = 1'b1;
        wait_done(40);
        checks++; if (obs_q.size() != NPIX) begin errors++; $display("FAIL pause_count: got %0d want %0d", obs_q.size(), NPIX); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL pause_data: got %h want %h", o, e); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL pause_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_restart();
        logic [7:0] e, o;
        clear_obs();
        frame_stored = 2'b11;
        // Pixels 4 and 5 are still in the read pipeline when the restart lands.
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'h20 + 8'(i));
        start_frame(1'b1);
        for (int i = 0; i < 30 && re1_cnt < 6; i++) tick();
        start_frame(1'b0);
        wait_done(40);
        checks++; if (obs_q.size() != 4 + NPIX) begin errors++; $display("FAIL restart_count: got %0d want %0d", obs_q.size(), 4 + NPIX); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL restart_data: got %h want %h", o, e); end
        end
        checks++; if (rrst0_cnt != 2) begin errors++; $display("FAIL restart_rrst: got %0d want 2", rrst0_cnt); end
        checks++; if (re0_cnt != NPIX) begin errors++; $display("FAIL restart_re0: got %0d want %0d", re0_cnt, NPIX); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL restart_overlap: got %0d want 0", overlap_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, o;
        int n;
        clear_obs();
        frame_stored = 2'b10;
        start_frame(1'b1);
        for (int i = 0; i < 30 && re1_cnt < 3; i++) tick();
        reset_n = 1'b0;
        tick();
        checks++; if ({image_data, buffer_ready, frame_done, fifo_rrst, fifo_re} !== 14'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h/%b/%b/%b/%b want all 0",
                     image_data, buffer_ready, frame_done, fifo_rrst, fifo_re);
        end
        reset_n = 1'b1;
        n = obs_q.size();
        repeat (6) tick();
        checks++; if (obs_q.size() != n) begin errors++; $display("FAIL midreset_ready: got %0d want %0d", obs_q.size(), n); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_done: got %0d want 0", done_cnt); end
        clear_obs();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'h10 + 8'(i));
        start_frame(1'b1);
        wait_done(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL midreset_data: got %h want %h", o, e); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL midreset_frame_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_testpat();
        logic [7:0] e, o;
        clear_obs();
        frame_stored = 2'b00;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(i));
        start_frame(1'b1);
        wait_done(40);
        checks++; if (obs_q.size() != NPIX) begin errors++; $display("FAIL tp_count: got %0d want %0d", obs_q.size(), NPIX); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
            checks++; if (o !== e) begin errors++; $display("FAIL tp_data: got %h want %h", o, e); end
        end
        checks++; if (re0_cnt + re1_cnt != 0) begin errors++; $display("FAIL tp_re: got %0d want 0", re0_cnt + re1_cnt); end
        checks++; if (rrst1_cnt != 2) begin errors++; $display("FAIL tp_rrst: got %0d want 2", rrst1_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL tp_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        reset_n      = 1'b0;
        new_image    = 1'b0;
        image_sel    = 1'b0;
        buffer_vref  = 1'b1;
        buffer_href  = 1'b1;
        frame_stored = 2'b00;
        clear_obs();
        test_reset();
`ifdef FRAME_READER_TESTPAT_EN
        test_testpat();
`else
        test_basic();
        test_wait_frame();
        test_pause();
        test_restart();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
